// File: rtl/delay_line_server.sv
// delay_line_server: shared-RAM server for up to n_lines circular delay lines with base/length config.
// Optional DELAY_INTERP_EN adds fractional-delay linear interpolation (second RAM read plus multiplier).
module delay_line_server #(
  parameter int data_width = 16,
  parameter int n_lines    = 16,
  parameter int mem_size   = 4096,
  parameter int frac_bits  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        delay_read_req,
  input  logic                        delay_write_req,
  input  logic [data_width-1:0]       delay_req_handle,
  input  logic [data_width-1:0]       delay_req_arg,
  output logic [data_width-1:0]       delay_req_data_out,
  output logic                        delay_read_ready,
  output logic                        delay_write_ready,
  input  logic                        cfg_write,
  input  logic [$clog2(n_lines)-1:0]  cfg_handle,
  input  logic [$clog2(mem_size)-1:0] cfg_base,
  input  logic [$clog2(mem_size):0]   cfg_length,
  output logic                        cfg_ack
);
  localparam int HW = $clog2(n_lines);
  localparam int AW = $clog2(mem_size);
  localparam int LW = AW + 1;
`ifdef DELAY_INTERP_EN
  localparam int FB = frac_bits;
  localparam int IW = data_width + frac_bits + 1;
  localparam logic signed [IW-1:0] MAXV = {{(frac_bits+2){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(frac_bits+2){1'b1}}, {(data_width-1){1'b0}}};
  typedef enum logic [3:0] {IDLE, RD_ADDR, RD_WAIT, RD_DATA, RD2_ADDR, RD2_WAIT, INTERP, WR, DONE} state_t;
`else
  localparam int FB = 0 * frac_bits;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, RD_DATA, WR, DONE} state_t;
`endif

  state_t state_q, state_d;
  logic [AW-1:0] base_q [n_lines];
  logic [LW-1:0] len_q [n_lines];
  logic [AW-1:0] wptr_q [n_lines];
  logic [data_width-1:0] mem [mem_size];
  logic pw_q, pc_q, v_q, rrdy_q, wrdy_q, ack_q;
  logic [data_width-1:0] pw_h_q, pw_a_q, a_q, rdata_q, out_q;
  logic [HW-1:0] pc_h_q, h_q;
  logic [AW-1:0] pc_b_q, a0_q, a1_q;
  logic [LW-1:0] pc_l_q;
  logic cfg_go, start_rd, start_wr, start_wp, vld;
  logic [data_width-1:0] sel_h, sel_a, d;
  logic [HW-1:0] idx, ch;
  logic [AW-1:0] cb, raddr;
  logic [LW-1:0] cl, ln, lm1, dc0, dc1;

  function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] bs, input logic [AW-1:0] wp,
                                            input logic [LW-1:0] len, input logic [LW-1:0] dc);
    logic [LW:0] o;
    o = {2'b0, wp} - {{LW{1'b0}}, 1'b1} - {1'b0, dc};
    if (o[LW]) o = o + {1'b0, len};
    return bs + o[AW-1:0];
  endfunction

  always_comb begin
    cfg_go   = state_q == IDLE && (pc_q || cfg_write);
    start_wp = state_q == IDLE && pw_q && !cfg_go;
    start_rd = state_q == IDLE && !pw_q && delay_read_req;
    start_wr = state_q == IDLE && !pw_q && !delay_read_req && delay_write_req;
    ch       = pc_q ? pc_h_q : cfg_handle;
    cb       = pc_q ? pc_b_q : cfg_base;
    cl       = pc_q ? pc_l_q : cfg_length;
    sel_h    = pw_q ? pw_h_q : delay_req_handle;
    sel_a    = pw_q ? pw_a_q : delay_req_arg;
    idx      = sel_h[HW-1:0];
    ln       = len_q[idx];
    lm1      = ln - LW'(1);
    vld      = int'(sel_h) < n_lines && ln != '0;
    d        = sel_a >> FB;
    dc0      = 32'(d) >= 32'(lm1) ? lm1 : LW'(d);
    dc1      = dc0 >= lm1 ? lm1 : dc0 + LW'(1);
    state_d  = state_q;
    case (state_q)
      IDLE:     state_d = (start_wp || start_wr) ? WR : start_rd ? RD_ADDR : IDLE;
      RD_ADDR:  state_d = RD_WAIT;
      RD_WAIT:  state_d = RD_DATA;
`ifdef DELAY_INTERP_EN
      RD_DATA:  state_d = RD2_ADDR;
      RD2_ADDR: state_d = RD2_WAIT;
      RD2_WAIT: state_d = INTERP;
`endif
      WR:       state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

`ifdef DELAY_INTERP_EN
  logic [data_width-1:0] s0_q, ip;
  logic signed [IW-1:0] s0x, s1x, prod, res;
  always_comb begin
    s0x  = {{(frac_bits+1){s0_q[data_width-1]}}, s0_q};
    s1x  = {{(frac_bits+1){rdata_q[data_width-1]}}, rdata_q};
    prod = (s1x - s0x) * $signed({{(data_width+1){1'b0}}, a_q[frac_bits-1:0]});
    res  = s0x + (prod >>> frac_bits);
    ip   = res > MAXV ? MAXV[data_width-1:0] : res < MINV ? MINV[data_width-1:0] : res[data_width-1:0];
  end
  always_ff @(posedge clk) if (state_q == RD_WAIT) s0_q <= rdata_q;
  assign raddr = state_q == RD2_ADDR ? a1_q : a0_q;
`else
  assign raddr = a0_q;
`endif

  // RAM is never cleared; a write caught by reset is abandoned.
  always_ff @(posedge clk) begin
    if (!reset && state_q == WR && v_q) mem[base_q[h_q] + wptr_q[h_q]] <= a_q;
    rdata_q <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pw_q    <= 1'b0;
      pc_q    <= 1'b0;
      rrdy_q  <= 1'b0;
      wrdy_q  <= 1'b0;
      ack_q   <= 1'b0;
      out_q   <= '0;
      for (int i = 0; i < n_lines; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        wptr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rrdy_q  <= 1'b0;
      wrdy_q  <= 1'b0;
      ack_q   <= cfg_go;
      if (cfg_write && (state_q != IDLE || pc_q)) begin
        pc_q   <= 1'b1;
        pc_h_q <= cfg_handle;
        pc_b_q <= cfg_base;
        pc_l_q <= cfg_length;
      end else if (cfg_go) pc_q <= 1'b0;
      if (cfg_go) begin
        base_q[ch] <= cb;
        len_q[ch]  <= cl;
        wptr_q[ch] <= '0;
      end
      if (start_rd || start_wr || start_wp) begin
        h_q  <= idx;
        a_q  <= sel_a;
        v_q  <= vld;
        a0_q <= rd_addr(base_q[idx], wptr_q[idx], ln, dc0);
        a1_q <= rd_addr(base_q[idx], wptr_q[idx], ln, dc1);
      end
      if (start_rd && delay_write_req) begin
        pw_q   <= 1'b1;
        pw_h_q <= delay_req_handle;
        pw_a_q <= delay_req_arg;
      end
      if (start_wp) pw_q <= 1'b0;
`ifdef DELAY_INTERP_EN
      if (state_q == RD2_WAIT) begin
        out_q  <= v_q ? ip : '0;
        rrdy_q <= 1'b1;
      end
`else
      if (state_q == RD_WAIT) begin
        out_q  <= v_q ? rdata_q : '0;
        rrdy_q <= 1'b1;
      end
`endif
      if (state_q == WR) begin
        wrdy_q <= 1'b1;
        if (v_q) wptr_q[h_q] <= ({1'b0, wptr_q[h_q]} == len_q[h_q] - LW'(1)) ? '0 : wptr_q[h_q] + AW'(1);
      end
    end
  end

  assign delay_req_data_out = out_q;
  assign delay_read_ready   = rrdy_q;
  assign delay_write_ready  = wrdy_q;
  assign cfg_ack            = ack_q;
endmodule
